// File: rtl/ball_pair_scanner_pkg.sv
// Shared billiard package for the ball pair scanner.
// Holds the scanner FSM state encoding and the pair-count helper that
// gives the number of unordered ball pairs for a given ball count.
package ball_pair_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  // Number of unordered pairs (i,j), i<j, among num_balls balls.
  function automatic int pair_count(input int num_balls);
    return (num_balls * (num_balls - 1)) / 2;
  endfunction

endpackage

// File: rtl/pair_distance_pipe.sv
// Two-stage collision datapath for one ball pair per cycle.
// Stage 1 registers the widened coordinate differences and the diameter,
// stage 2 registers the squared distance and squared diameter; a pair
// collides when the squared distance is strictly below the squared diameter.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   en                    : advance enable; low freezes both stages
//   in_valid, in_i, in_j  : pair being issued and its ball indices
//   xi, xj, yi, yj        : signed coordinates of balls i and j
//   radius                : signed non-negative common radius
//   s1_valid              : stage 1 holds a pair (used for drain detection)
//   hit_valid, hit_i/j    : stage 2 holds a colliding pair and its indices
module pair_distance_pipe #(
  parameter int N     = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_i,
  input  logic [IDX_W-1:0] in_j,
  input  logic [N-1:0]     xi,
  input  logic [N-1:0]     xj,
  input  logic [N-1:0]     yi,
  input  logic [N-1:0]     yj,
  input  logic [N-1:0]     radius,
  output logic             s1_valid,
  output logic             hit_valid,
  output logic [IDX_W-1:0] hit_i,
  output logic [IDX_W-1:0] hit_j
);

  localparam int SW = 2 * N + 3;

  logic                 s1_valid_r;
  logic [IDX_W-1:0]     s1_i_r;
  logic [IDX_W-1:0]     s1_j_r;
  logic [N:0]           dx_r;
  logic [N:0]           dy_r;
  logic [N:0]           r2_r;
  logic                 s2_valid_r;
  logic [IDX_W-1:0]     s2_i_r;
  logic [IDX_W-1:0]     s2_j_r;
  logic signed [SW-1:0] dist2_r;
  logic signed [SW-1:0] r2sq_r;

  logic [N:0]           dx_s;
  logic [N:0]           dy_s;
  logic [N:0]           r2_s;
  logic signed [SW-1:0] dx_ext_s;
  logic signed [SW-1:0] dy_ext_s;
  logic signed [SW-1:0] r2_ext_s;

  // One extra bit on each operand so the difference of two extreme
  // coordinates cannot wrap.
  assign dx_s = {xi[N-1], xi} - {xj[N-1], xj};
  assign dy_s = {yi[N-1], yi} - {yj[N-1], yj};
  assign r2_s = {radius, 1'b0};

  // Sign-extend to the full square width so the products and their sum fit.
  assign dx_ext_s = {{(N + 2){dx_r[N]}}, dx_r};
  assign dy_ext_s = {{(N + 2){dy_r[N]}}, dy_r};
  assign r2_ext_s = {{(N + 2){r2_r[N]}}, r2_r};

  // Difference stage then square stage, both frozen while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_i_r     <= {IDX_W{1'b0}};
      s1_j_r     <= {IDX_W{1'b0}};
      dx_r       <= {(N + 1){1'b0}};
      dy_r       <= {(N + 1){1'b0}};
      r2_r       <= {(N + 1){1'b0}};
      s2_valid_r <= 1'b0;
      s2_i_r     <= {IDX_W{1'b0}};
      s2_j_r     <= {IDX_W{1'b0}};
      dist2_r    <= {SW{1'b0}};
      r2sq_r     <= {SW{1'b0}};
    end else if (en) begin
      s1_valid_r <= in_valid;
      s1_i_r     <= in_i;
      s1_j_r     <= in_j;
      dx_r       <= dx_s;
      dy_r       <= dy_s;
      r2_r       <= r2_s;
      s2_valid_r <= s1_valid_r;
      s2_i_r     <= s1_i_r;
      s2_j_r     <= s1_j_r;
      dist2_r    <= dx_ext_s * dx_ext_s + dy_ext_s * dy_ext_s;
      r2sq_r     <= r2_ext_s * r2_ext_s;
    end
  end

  // Touching balls (distance exactly 2r) are not a collision.
  assign s1_valid  = s1_valid_r;
  assign hit_valid = s2_valid_r & (dist2_r < r2sq_r);
  assign hit_i     = s2_i_r;
  assign hit_j     = s2_j_r;

endmodule

// File: rtl/ball_pair_scanner.sv
// Ball pair collision scanner.
// On start, snapshots all ball positions and the common radius, then walks
// every pair (i,j), i<j, in row-major order through a two-stage distance
// pipeline and presents only colliding pairs on a valid/ready handshake.
// A backpressured output freezes the pipeline and the pair walker.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : one-cycle scan request, ignored while busy
//   xs, ys                : packed signed coordinates, ball k at [k*N +: N]
//   radius                : signed non-negative common radius
//   busy                  : scan in progress (through the done cycle)
//   pair_valid/ready      : colliding pair handshake
//   pair_i, pair_j        : lower and higher ball index of the pair
//   done                  : one-cycle pulse when the scan has fully drained
//   hit_count             : accepted pairs in the last or current scan
module ball_pair_scanner
  import ball_pair_scanner_pkg::*;
#(
  parameter int N         = 32,
  parameter int NUM_BALLS = 16,
  parameter int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_BALLS*N-1:0] xs,
  input  logic [NUM_BALLS*N-1:0] ys,
  input  logic [N-1:0]           radius,
  output logic                   busy,
  output logic                   pair_valid,
  input  logic                   pair_ready,
  output logic [IDX_W-1:0]       pair_i,
  output logic [IDX_W-1:0]       pair_j,
  output logic                   done,
  output logic [2*IDX_W-1:0]     hit_count
);

  localparam int               NUM_PAIRS = pair_count(NUM_BALLS);
  localparam int               CNT_W     = 2 * IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BALLS - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO   = IDX_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  scan_state_e            state_r;
  logic [NUM_BALLS*N-1:0] xs_r;
  logic [NUM_BALLS*N-1:0] ys_r;
  logic [N-1:0]           radius_r;
  logic [IDX_W-1:0]       i_r;
  logic [IDX_W-1:0]       j_r;
  logic [CNT_W-1:0]       k_r;
  logic                   busy_r;
  logic                   done_r;
  logic [CNT_W-1:0]       hit_count_r;

  logic                   en_s;
  logic                   issue_s;
  logic                   last_s;
  logic                   accept_s;
  logic                   s1_valid_s;
  logic                   pair_valid_s;
  logic [IDX_W-1:0]       pair_i_s;
  logic [IDX_W-1:0]       pair_j_s;
  logic [N-1:0]           xi_s;
  logic [N-1:0]           xj_s;
  logic [N-1:0]           yi_s;
  logic [N-1:0]           yj_s;

  // A presented pair that is not taken freezes everything upstream.
  assign en_s     = ~(pair_valid_s & ~pair_ready);
  assign issue_s  = (state_r == SCAN);
  assign last_s   = (k_r == LAST_PAIR);
  assign accept_s = pair_valid_s & pair_ready;

  assign xi_s = xs_r[i_r * N +: N];
  assign xj_s = xs_r[j_r * N +: N];
  assign yi_s = ys_r[i_r * N +: N];
  assign yj_s = ys_r[j_r * N +: N];

  pair_distance_pipe #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (en_s),
    .in_valid  (issue_s),
    .in_i      (i_r),
    .in_j      (j_r),
    .xi        (xi_s),
    .xj        (xj_s),
    .yi        (yi_s),
    .yj        (yj_s),
    .radius    (radius_r),
    .s1_valid  (s1_valid_s),
    .hit_valid (pair_valid_s),
    .hit_i     (pair_i_s),
    .hit_j     (pair_j_s)
  );

  // Scan FSM: snapshot and pair walker, drain detection, busy/done/hit_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      xs_r        <= {(NUM_BALLS * N){1'b0}};
      ys_r        <= {(NUM_BALLS * N){1'b0}};
      radius_r    <= {N{1'b0}};
      i_r         <= {IDX_W{1'b0}};
      j_r         <= {IDX_W{1'b0}};
      k_r         <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_count_r <= {CNT_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        hit_count_r <= hit_count_r + CNT_ONE;
      end
      case (state_r)
        IDLE: begin
          // busy_r is still high during the done cycle, so a start
          // arriving there is dropped like any other start while busy.
          busy_r <= 1'b0;
          if (start && !busy_r) begin
            state_r     <= SCAN;
            busy_r      <= 1'b1;
            xs_r        <= xs;
            ys_r        <= ys;
            radius_r    <= radius;
            i_r         <= {IDX_W{1'b0}};
            j_r         <= IDX_ONE;
            k_r         <= {CNT_W{1'b0}};
            hit_count_r <= {CNT_W{1'b0}};
          end
        end
        SCAN: begin
          if (en_s) begin
            k_r <= k_r + CNT_ONE;
            if (j_r == LAST_IDX) begin
              i_r <= i_r + IDX_ONE;
              j_r <= i_r + IDX_TWO;
            end else begin
              j_r <= j_r + IDX_ONE;
            end
            if (last_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Stage 1 empty and stage 2 retiring this edge: pipeline is empty next cycle.
          if (en_s && !s1_valid_s) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign hit_count  = hit_count_r;
  assign pair_valid = pair_valid_s;
  assign pair_i     = pair_i_s;
  assign pair_j     = pair_j_s;

endmodule

// File: tb/tb_ball_pair_scanner.sv
// Self-checking bench for ball_pair_scanner: a table of four-ball scenes,
// randomized scenes against a pair/timing reference model, a reset-abort
// sequence, and two-ball scenes on a second instance.
module tb_ball_pair_scanner;

  logic         clk = 1'b0;
  logic         reset;
  // four-ball instance
  logic         start;
  logic [127:0] xs, ys;
  logic [31:0]  radius;
  logic         ready;
  logic         busy, pv, done;
  logic [1:0]   pi, pj;
  logic [3:0]   hc;
  // two-ball instance
  logic         start2;
  logic [63:0]  xs2, ys2;
  logic [31:0]  radius2;
  logic         ready2;
  logic         busy2, pv2, done2;
  logic [0:0]   pi2, pj2;
  logic [1:0]   hc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_pair_scanner #(.N(32), .NUM_BALLS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .xs(xs), .ys(ys), .radius(radius),
    .busy(busy), .pair_valid(pv), .pair_ready(ready), .pair_i(pi), .pair_j(pj),
    .done(done), .hit_count(hc)
  );

  ball_pair_scanner #(.N(32), .NUM_BALLS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .xs(xs2), .ys(ys2), .radius(radius2),
    .busy(busy2), .pair_valid(pv2), .pair_ready(ready2), .pair_i(pi2), .pair_j(pj2),
    .done(done2), .hit_count(hc2)
  );

  typedef struct packed {
    logic [3:0][31:0] x;
    logic [3:0][31:0] y;
    logic [31:0]      r;
    logic [7:0]       w0;
    logic [7:0]       hits;
    logic [7:0]       done_cyc;
  } vec_t;

  vec_t vecs [6];

  // reference model state
  int cur_x [4];
  int cur_y [4];
  int cur_r;
  int wait_h [6];
  int exp_i [6];
  int exp_j [6];
  int exp_k [6];
  int n_exp;
  int got_done;
  int got_hits;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2, x3, y3,
                              input int r, w0, hits, dn);
    vec_t v;
    v.x = {x3, x2, x1, x0};
    v.y = {y3, y2, y1, y0};
    v.r = r;
    v.w0 = 8'(w0);
    v.hits = 8'(hits);
    v.done_cyc = 8'(dn);
    return v;
  endfunction

  // Colliding pairs in row-major order: squared distance below squared diameter.
  function automatic void build_model();
    int k;
    longint dx, dy, d;
    n_exp = 0;
    k = 0;
    d = 2 * longint'(cur_r);
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        dx = longint'(cur_x[i]) - longint'(cur_x[j]);
        dy = longint'(cur_y[i]) - longint'(cur_y[j]);
        if (dx * dx + dy * dy < d * d) begin
          exp_i[n_exp] = i;
          exp_j[n_exp] = j;
          exp_k[n_exp] = k;
          n_exp++;
        end
        k++;
      end
    end
  endfunction

  // One full scan; hit h waits wait_h[h] cycles before being accepted.
  // Hit h should first appear at t+3+k_h plus all earlier waits, done at t+9 plus all waits.
  task automatic run_scan();
    int cyc, h, held, sumw;
    build_model();
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      xs[b*32 +: 32] = cur_x[b];
      ys[b*32 +: 32] = cur_y[b];
    end
    radius = cur_r;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xs = {$urandom, $urandom, $urandom, $urandom};
    ys = {$urandom, $urandom, $urandom, $urandom};
    radius = $urandom;
    cyc = 1; h = 0; held = 0; sumw = 0; got_done = -1;
    while (cyc <= 100) begin
      chk("busy_during_scan", busy, 1);
      start = (cyc == 2);
      if (pv) begin
        if (h >= n_exp) begin
          chk("unexpected_pair", pv, 0);
          ready = 1'b1;
        end else begin
          chk("pair_i", pi, exp_i[h]);
          chk("pair_j", pj, exp_j[h]);
          if (held == 0) chk("pair_time", cyc, 3 + exp_k[h] + sumw);
          if (held < wait_h[h]) begin
            ready = 1'b0;
            held++;
          end else begin
            ready = 1'b1;
            sumw += held;
            held = 0;
            h++;
          end
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        got_done = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    got_hits = hc;
    if (got_done < 0) begin
      chk("done_timeout", done, 1);
    end else begin
      chk("done_cycle", got_done, 9 + sumw);
      chk("pairs_seen", h, n_exp);
      chk("hit_count", hc, n_exp);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("hit_count_hold", hc, n_exp);
    chk("no_restart", pv, 0);
  endtask

  // Two-ball scene on the second instance: P=1, done at t+4.
  task automatic run2(input logic [31:0] x0, x1, y0, y1, r, input int exp_hit);
    int cyc, nv, gd;
    @(negedge clk);
    xs2 = {x1, x0};
    ys2 = {y1, y0};
    radius2 = r;
    start2 = 1'b1;
    ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1; nv = 0; gd = -1;
    while (cyc <= 20) begin
      chk("p2_busy", busy2, 1);
      if (pv2) begin
        nv++;
        chk("p2_time", cyc, 3);
        chk("p2_i", pi2, 0);
        chk("p2_j", pj2, 1);
      end
      if (done2) begin
        gd = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("p2_valid_count", nv, exp_hit);
    chk("p2_done_cycle", gd, 4);
    chk("p2_hit_count", hc2, exp_hit);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0; xs = '0; ys = '0; radius = '0; ready = 1'b1;
    start2 = 1'b0; xs2 = '0; ys2 = '0; radius2 = '0; ready2 = 1'b1;

    vecs[0] = mk(0, 0, 15, 0, 100, 100, 100, 119, 10, 0, 2, 9);
    vecs[1] = mk(0, 0, 15, 0, 100, 100, 100, 119, 10, 5, 2, 14);
    vecs[2] = mk(0, 0, 20, 0, 500, 500, -500, -500, 10, 0, 0, 9);
    vecs[3] = mk(7, 7, 7, 7, 7, 7, 7, 7, 0, 0, 0, 9);
    vecs[4] = mk(0, 0, 1, 1, 2, 2, 3, 3, 5, 2, 6, 11);
    vecs[5] = mk(-10, -10, -3, -14, 1000, -1000, -1000, 1000, 5, 1, 1, 10);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_pair_valid", pv, 0);
    chk("rst_done", done, 0);
    chk("rst_pair_i", pi, 0);
    chk("rst_pair_j", pj, 0);
    chk("rst_hit_count", hc, 0);

    // table-driven scenes
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 4; b++) begin
        cur_x[b] = int'(vecs[v].x[b]);
        cur_y[b] = int'(vecs[v].y[b]);
      end
      cur_r = int'(vecs[v].r);
      for (int h = 0; h < 6; h++) wait_h[h] = 0;
      wait_h[0] = int'(vecs[v].w0);
      run_scan();
      chk("tbl_hits", got_hits, vecs[v].hits);
      chk("tbl_done", got_done, vecs[v].done_cyc);
    end

    // randomized scenes with random backpressure
    for (int n = 0; n < 25; n++) begin
      for (int b = 0; b < 4; b++) begin
        cur_x[b] = int'($urandom_range(0, 80)) - 40;
        cur_y[b] = int'($urandom_range(0, 80)) - 40;
      end
      cur_r = int'($urandom_range(0, 20));
      for (int h = 0; h < 6; h++) wait_h[h] = int'($urandom_range(0, 3));
      run_scan();
    end

    // start re-pulsed at t+3, reset at t+5: scan aborts silently
    @(negedge clk);
    xs = {32'd100, 32'd100, 32'd15, 32'd0};
    ys = {32'd119, 32'd100, 32'd0, 32'd0};
    radius = 32'd10;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc <= 5; cyc++) begin
      start = (cyc == 3);
      if (cyc == 3) chk("abort_first_pair", pv, 1);
      if (cyc == 4) chk("abort_busy", busy, 1);
      reset = (cyc == 5);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    chk("abort_busy_zero", busy, 0);
    chk("abort_valid_zero", pv, 0);
    chk("abort_done_zero", done, 0);
    chk("abort_pair_i_zero", pi, 0);
    chk("abort_pair_j_zero", pj, 0);
    chk("abort_hit_count_zero", hc, 0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_pair", pv, 0);
      chk("abort_idle", busy, 0);
    end

    // two-ball scenes
    run2(32'd0, 32'd20, 32'd0, 32'd0, 32'd10, 0);
    run2(32'h8000_0000, 32'h7FFF_FFFF, 32'd5, 32'd5, 32'd10, 0);
    run2(32'd0, 32'd5, 32'd0, 32'd5, 32'd10, 1);
    run2(32'hFFFF_FFF6, 32'hFFFF_FFF0, 32'd3, 32'd1, 32'd4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_pair_scanner.md
BALL_PAIR_SCANNER -- requirements
Module: ball_pair_scanner

Interface
REQ-001 SHALL have parameter N, default 32: signed coordinate/radius width in bits.
REQ-002 SHALL have parameter NUM_BALLS, default 16: ball count, legal range 2..64.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_BALLS): ball index width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to scan all ball pairs.
REQ-007 SHALL have port xs, input, NUM_BALLS*N: packed signed x coordinates; ball k occupies bits [k*N +: N].
REQ-008 SHALL have port ys, input, NUM_BALLS*N: packed signed y coordinates, same packing as xs.
REQ-009 SHALL have port radius, input, N: signed common ball radius, non-negative.
REQ-010 SHALL have port busy, output, 1: scan in progress.
REQ-011 SHALL have port pair_valid, output, 1: colliding pair presented on pair_i/pair_j.
REQ-012 SHALL have port pair_ready, input, 1: downstream accepts the pair when high with pair_valid.
REQ-013 SHALL have port pair_i, output, IDX_W: lower index of the colliding pair.
REQ-014 SHALL have port pair_j, output, IDX_W: higher index of the colliding pair.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at scan completion.
REQ-016 SHALL have port hit_count, output, 2*IDX_W: colliding pairs found in the last or current scan.

Function
REQ-017 SHALL use FSM states IDLE, SCAN, DRAIN; start in IDLE moves to SCAN; issuing the last pair moves to DRAIN; pipeline and output register empty moves to IDLE and asserts done.
REQ-018 SHALL snapshot xs, ys and radius in the start cycle t; later input changes SHALL NOT affect the running scan.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL issue pairs (i,j), i<j, in row-major order (0,1),(0,2)..(0,NUM_BALLS-1),(1,2)..; P=NUM_BALLS*(NUM_BALLS-1)/2 pairs, one per unstalled cycle; pair k issues at t+1+k.
REQ-021 SHALL use a 2-stage pipeline: stage 1 registers dx, dy as N+1-bit signed differences (no wrap) and 2r as N+1 bits; stage 2 registers dx^2+dy^2 and (2r)^2 at 2N+3 bits; compare is strictly less-than.
REQ-022 SHALL present only colliding pairs; result of pair k is valid at t+3+k without stalls.
REQ-023 SHALL hold pair_valid, pair_i and pair_j stable until pair_ready is sampled high; while pair_valid=1 and pair_ready=0 the whole pipeline and pair counter SHALL stall.
REQ-024 SHALL increment hit_count on each accepted pair; clear hit_count at scan start; hold it after done.
REQ-025 SHALL assert busy from t+1 until the done cycle inclusive; done SHALL occur the cycle after the last pair is retired (accepted or non-colliding), i.e. t+P+3 without stalls.
REQ-026 SHALL treat distance exactly 2r as no collision; radius 0 SHALL yield no collisions.

Reset
REQ-027 SHALL, on reset, force IDLE with busy=0, pair_valid=0, done=0, pair_i=0, pair_j=0, hit_count=0, pipeline valid flags cleared.
REQ-028 SHALL abort any scan on reset mid-operation, emitting neither further pairs nor done.

Structure
REQ-029 SHALL place the FSM state encodings and the pair-count function (P from NUM_BALLS) in the shared billiard package.
REQ-030 SHALL instantiate one sub-module, pair_distance_pipe, holding the 2-stage difference/square/compare datapath with stall enable.

Verification
REQ-031 SHALL test NUM_BALLS=4, r=10, balls (0,0),(15,0),(100,100),(100,119), pair_ready=1 -> pairs (0,1) then (2,3), hit_count=2, done at t+9.
REQ-032 SHALL test balls (0,0),(20,0), r=10 -> no pair_valid, hit_count=0, done at t+4.
REQ-033 SHALL test REQ-031 with pair_ready low 5 cycles at first valid -> (0,1) held stable 5 cycles, same order and count, done at t+14.
REQ-034 SHALL test N=32 with x0=-2^31, x1=2^31-1, equal y, r=10 -> no collision (no wrap).
REQ-035 SHALL test start re-pulsed at t+3 and reset at t+5 -> second start ignored; after reset all outputs zero, no done.
